bus_wait_sequencer: RTL and testbench

- Sequences host-bus accesses from the decoded chip-select path toward slow peripheral register blocks, and drives the host Wait line.
- Inserts a per-region programmable number of wait states, then issues a single-cycle peripheral strobe.
- Waits for a peripheral acknowledge or a timeout, holds read data stable until the host ends the cycle, then releases Wait.
- Sits between the host bus decode (Cs/Rd/Wr, active-high) and the peripheral register bus, replacing the tied-off Wait.

---
 rtl/bus_wait_sequencer_pkg.sv | 21 ++
 rtl/bus_ws_cfg_regs.sv | 32 +++
 rtl/bus_wait_sequencer.sv | 148 ++++++++++++++
 tb/tb_bus_wait_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_wait_sequencer_pkg.sv
// Shared types and constants for the host-bus wait-state sequencer.
package bus_wait_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WS,
        STROBE,
        ACK,
        DONE
    } state_t;

    localparam int unsigned REGION_W    = 2;
    localparam int unsigned NUM_REGIONS = 1 << REGION_W;

    // Read data returned to the host when the peripheral never acknowledges.
    localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

    // A config write of all-ones to this region also clears the sticky timeout flag.
    localparam logic [REGION_W-1:0] CLEAR_REGION = REGION_W'(3);

endpackage

// File: rtl/bus_ws_cfg_regs.sv
// Per-region wait-state register file: one write port, combinational read by region.
module bus_ws_cfg_regs
    import bus_wait_sequencer_pkg::*;
#(
    parameter int unsigned WS_W     = 4,
    parameter int unsigned WS_RESET = 2
) (
    input  logic                Clk,
    input  logic                ResetN,
    input  logic                CfgWr,
    input  logic [REGION_W-1:0] CfgRegion,
    input  logic [WS_W-1:0]     CfgData,
    input  logic [REGION_W-1:0] Region,
    output logic [WS_W-1:0]     WsOut
);

    logic [WS_W-1:0] wsReg [NUM_REGIONS];

    // Config writes land in any state; the sequencer copies its count at access start.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
                wsReg[i] <= WS_W'(WS_RESET);
            end
        end else if (CfgWr) begin
            wsReg[CfgRegion] <= CfgData;
        end
    end

    assign WsOut = wsReg[Region];

endmodule

// File: rtl/bus_wait_sequencer.sv
// Host-bus wait-state sequencer: stretches host cycles with Wait, inserts
// per-region wait states, issues one peripheral strobe and waits for PAck or timeout.
module bus_wait_sequencer
    import bus_wait_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned WS_W     = 4,
    parameter int unsigned WS_RESET = 2,
    parameter int unsigned TO_W     = 8
) (
    input  logic                Clk,
    input  logic                ResetN,
    input  logic [ADDR_W-1:0]   Addr,
    input  logic [DATA_W-1:0]   DataWr,
    input  logic                Cs,
    input  logic                Rd,
    input  logic                Wr,
    output logic                Wait,
    output logic [DATA_W-1:0]   DataRd,
    input  logic                CfgWr,
    input  logic [REGION_W-1:0] CfgRegion,
    input  logic [WS_W-1:0]     CfgData,
    output logic [ADDR_W-1:0]   PAddr,
    output logic [DATA_W-1:0]   PDataWr,
    output logic                PRd,
    output logic                PWr,
    input  logic [DATA_W-1:0]   PDataRd,
    input  logic                PAck,
    output logic                TimeoutErr
);

    state_t              state;
    logic [WS_W-1:0]     wsCnt;
    logic [TO_W-1:0]     toCnt;
    logic                dirRd;
    logic [WS_W-1:0]     wsSel;
    logic [REGION_W-1:0] region;
    logic                hostActive;
    logic                timeoutHit;
    logic                clearCmd;

    assign hostActive = Cs & (Rd | Wr);
    assign region     = Addr[ADDR_W-1 -: REGION_W];
    assign timeoutHit = (state == ACK) && !PAck && (toCnt == '1);
    assign clearCmd   = CfgWr && (CfgRegion == CLEAR_REGION) && (CfgData == '1);

    bus_ws_cfg_regs #(
        .WS_W     (WS_W),
        .WS_RESET (WS_RESET)
    ) u_cfg (
        .Clk       (Clk),
        .ResetN    (ResetN),
        .CfgWr     (CfgWr),
        .CfgRegion (CfgRegion),
        .CfgData   (CfgData),
        .Region    (region),
        .WsOut     (wsSel)
    );

    // Wait rises with the start condition and drops in the cycle PAck or the timeout resolves.
    always_comb begin
        Wait = 1'b0;
        case (state)
            IDLE:       Wait = hostActive & ResetN;
            WS, STROBE: Wait = 1'b1;
            ACK:        Wait = !(PAck || (toCnt == '1));
            default:    Wait = 1'b0;
        endcase
    end

    // Access sequencer; strobes are registered so they are high exactly in STROBE.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state   <= IDLE;
            wsCnt   <= '0;
            toCnt   <= '0;
            dirRd   <= 1'b0;
            PAddr   <= '0;
            PDataWr <= '0;
            PRd     <= 1'b0;
            PWr     <= 1'b0;
            DataRd  <= '0;
        end else begin
            PRd <= 1'b0;
            PWr <= 1'b0;
            case (state)
                IDLE: begin
                    if (hostActive) begin
                        PAddr   <= Addr;
                        PDataWr <= DataWr;
                        dirRd   <= Rd;
                        wsCnt   <= wsSel;
                        if (wsSel == '0) begin
                            state <= STROBE;
                            PRd   <= Rd;
                            PWr   <= !Rd;
                        end else begin
                            state <= WS;
                        end
                    end
                end
                WS: begin
                    if (!hostActive) begin
                        state <= IDLE;
                    end else if (wsCnt == WS_W'(1)) begin
                        state <= STROBE;
                        PRd   <= dirRd;
                        PWr   <= !dirRd;
                    end else begin
                        wsCnt <= wsCnt - WS_W'(1);
                    end
                end
                STROBE: begin
                    toCnt <= '0;
                    state <= ACK;
                end
                ACK: begin
                    if (PAck) begin
                        if (dirRd) DataRd <= PDataRd;
                        state <= DONE;
                    end else if (toCnt == '1) begin
                        if (dirRd) DataRd <= DATA_W'(TIMEOUT_DATA);
                        state <= DONE;
                    end else begin
                        toCnt <= toCnt + TO_W'(1);
                    end
                end
                DONE: begin
                    if (!hostActive) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky timeout flag; a timeout in the same cycle as the clear write wins.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            TimeoutErr <= 1'b0;
        end else if (timeoutHit) begin
            TimeoutErr <= 1'b1;
        end else if (clearCmd) begin
            TimeoutErr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_wait_sequencer.sv
// Scoreboard bench for bus_wait_sequencer: host tasks queue expected strobes and
// completions, an independent monitor checks them as the DUT presents them.
module tb_bus_wait_sequencer;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int WS_W   = 4;
    localparam int TO_W   = 8;

    logic              Clk = 1'b0;
    logic              ResetN;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] DataWr;
    logic              Cs, Rd, Wr;
    logic              Wait;
    logic [DATA_W-1:0] DataRd;
    logic              CfgWr;
    logic [1:0]        CfgRegion;
    logic [WS_W-1:0]   CfgData;
    logic [ADDR_W-1:0] PAddr;
    logic [DATA_W-1:0] PDataWr;
    logic              PRd, PWr;
    logic [DATA_W-1:0] PDataRd;
    logic              PAck;
    logic              TimeoutErr;

    bus_wait_sequencer #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .WS_W     (WS_W),
        .WS_RESET (2),
        .TO_W     (TO_W)
    ) dut (
        .Clk        (Clk),
        .ResetN     (ResetN),
        .Addr       (Addr),
        .DataWr     (DataWr),
        .Cs         (Cs),
        .Rd         (Rd),
        .Wr         (Wr),
        .Wait       (Wait),
        .DataRd     (DataRd),
        .CfgWr      (CfgWr),
        .CfgRegion  (CfgRegion),
        .CfgData    (CfgData),
        .PAddr      (PAddr),
        .PDataWr    (PDataWr),
        .PRd        (PRd),
        .PWr        (PWr),
        .PDataRd    (PDataRd),
        .PAck       (PAck),
        .TimeoutErr (TimeoutErr)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic              isRd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                pos;
    } strobe_t;

    typedef struct {
        int                waitLen;
        logic              checkData;
        logic [DATA_W-1:0] dataRd;
        logic              toErr;
    } done_t;

    strobe_t strobeQ[$];
    done_t   doneQ[$];

    int checks = 0;
    int errors = 0;

    logic              ackEnable = 1'b1;
    logic [DATA_W-1:0] ackData   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Peripheral model: acknowledges in the first ACK cycle when enabled.
    initial begin : periph
        PAck    = 1'b0;
        PDataRd = '0;
        forever begin
            @(negedge Clk);
            if ((PRd || PWr) && ackEnable) begin
                @(posedge Clk); #1;
                PAck    = 1'b1;
                PDataRd = ackData;
                @(posedge Clk); #1;
                PAck    = 1'b0;
                PDataRd = '0;
            end
        end
    end

    // Monitor: checks strobes and completions against the queues.
    initial begin : monitor
        int      run;
        logic    prevWait;
        logic    pending;
        done_t   cur;
        strobe_t s;
        run      = 0;
        prevWait = 1'b0;
        pending  = 1'b0;
        cur      = '{0, 1'b0, '0, 1'b0};
        forever begin
            @(negedge Clk);
            if (!ResetN) begin
                run      = 0;
                prevWait = 1'b0;
                pending  = 1'b0;
            end else begin
                if (pending) begin
                    pending = 1'b0;
                    if (cur.checkData) check("DataRd", 32'(DataRd), 32'(cur.dataRd));
                    check("TimeoutErr", 32'(TimeoutErr), 32'(cur.toErr));
                end
                if (Wait) run++;
                if (PRd || PWr) begin
                    if (strobeQ.size() == 0) begin
                        check("unexpected strobe", 32'({PRd, PWr}), 32'd0);
                    end else begin
                        s = strobeQ.pop_front();
                        check("strobe dir", 32'({PRd, PWr}), s.isRd ? 32'd2 : 32'd1);
                        check("PAddr", 32'(PAddr), 32'(s.addr));
                        check("PDataWr", 32'(PDataWr), 32'(s.data));
                        check("strobe position", run, s.pos);
                    end
                end
                if (!Wait && prevWait) begin
                    if (doneQ.size() == 0) begin
                        check("unexpected completion", run, 0);
                    end else begin
                        cur = doneQ.pop_front();
                        check("Wait length", run, cur.waitLen);
                        pending = 1'b1;
                    end
                    run = 0;
                end
                prevWait = Wait;
            end
        end
    end

    task automatic cfgWrite(input logic [1:0] region, input logic [WS_W-1:0] val);
        @(posedge Clk); #1;
        CfgWr     = 1'b1;
        CfgRegion = region;
        CfgData   = val;
        @(posedge Clk); #1;
        CfgWr     = 1'b0;
    endtask

    // One host access; ackCycles is the number of Wait-high ACK cycles expected.
    task automatic hostAccess(input logic isRd, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] wdata, input int ws,
                              input logic checkData, input logic [DATA_W-1:0] expData,
                              input logic expTo, input int ackCycles,
                              input logic cfgSame, input logic [1:0] cfgReg,
                              input logic [WS_W-1:0] cfgVal);
        strobe_t s;
        done_t   d;
        int      n;
        s.isRd = isRd; s.addr = addr; s.data = wdata; s.pos = ws + 2;
        d.waitLen = ws + 2 + ackCycles; d.checkData = checkData;
        d.dataRd = expData; d.toErr = expTo;
        strobeQ.push_back(s);
        doneQ.push_back(d);
        @(posedge Clk); #1;
        Cs = 1'b1; Rd = isRd; Wr = !isRd; Addr = addr; DataWr = wdata;
        if (cfgSame) begin
            CfgWr = 1'b1; CfgRegion = cfgReg; CfgData = cfgVal;
        end
        @(posedge Clk); #1;
        CfgWr = 1'b0;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (Wait && n < 400);
        if (Wait) check("Wait release", 32'(Wait), 32'd0);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Cs = 1'b0; Rd = 1'b0; Wr = 1'b0;
        @(posedge Clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        done_t   d;
        strobe_t s;
        int      n;
        ResetN = 1'b1;
        Cs = 1'b0; Rd = 1'b0; Wr = 1'b0;
        Addr = '0; DataWr = '0;
        CfgWr = 1'b0; CfgRegion = '0; CfgData = '0;
        #2 ResetN = 1'b0;
        #20;
        check("reset Wait", 32'(Wait), 32'd0);
        check("reset PRd", 32'(PRd), 32'd0);
        check("reset PWr", 32'(PWr), 32'd0);
        check("reset DataRd", 32'(DataRd), 32'd0);
        check("reset PAddr", 32'(PAddr), 32'd0);
        check("reset PDataWr", 32'(PDataWr), 32'd0);
        check("reset TimeoutErr", 32'(TimeoutErr), 32'd0);
        @(posedge Clk); #1;
        ResetN = 1'b1;
        repeat (2) @(posedge Clk);

        // Read, region 0, default ws=2, ack in first ACK cycle.
        ackData = 16'h1234;
        hostAccess(1'b1, 12'h010, 16'h5555, 2, 1'b1, 16'h1234, 1'b0, 0, 1'b0, 2'd0, 4'd0);
        check("DataRd held after Cs", 32'(DataRd), 32'h1234);

        // Write, region 1 configured to ws=0.
        cfgWrite(2'd1, 4'd0);
        hostAccess(1'b0, 12'h4A0, 16'hA5A5, 0, 1'b1, 16'h1234, 1'b0, 0, 1'b0, 2'd0, 4'd0);

        // Timeout: no ack for a read in region 0 (ws=2).
        ackEnable = 1'b0;
        hostAccess(1'b1, 12'h020, 16'h0000, 2, 1'b1, 16'hDEAD, 1'b1, 255, 1'b0, 2'd0, 4'd0);
        ackEnable = 1'b1;
        cfgWrite(2'd3, 4'hF);
        @(negedge Clk);
        check("TimeoutErr cleared", 32'(TimeoutErr), 32'd0);

        // Abort in WS: region 2 at ws=5, Cs dropped after two WS cycles.
        cfgWrite(2'd2, 4'd5);
        d.waitLen = 4; d.checkData = 1'b0; d.dataRd = '0; d.toErr = 1'b0;
        doneQ.push_back(d);
        @(posedge Clk); #1;
        Cs = 1'b1; Rd = 1'b1; Wr = 1'b0; Addr = 12'h800; DataWr = 16'h0000;
        repeat (3) begin @(posedge Clk); #1; end
        Cs = 1'b0; Rd = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check("abort Wait", 32'(Wait), 32'd0);
        repeat (8) @(posedge Clk);
        #1;

        // Config write on the start cycle is not seen by that access.
        ackData = 16'hBEEF;
        hostAccess(1'b1, 12'h030, 16'h1111, 2, 1'b1, 16'hBEEF, 1'b0, 0, 1'b1, 2'd0, 4'd7);
        ackData = 16'h0F0F;
        hostAccess(1'b1, 12'h031, 16'h2222, 7, 1'b1, 16'h0F0F, 1'b0, 0, 1'b0, 2'd0, 4'd0);

        // Reset asserted while waiting for an ack.
        ackEnable = 1'b0;
        s.isRd = 1'b1; s.addr = 12'h040; s.data = 16'h3333; s.pos = 9;
        strobeQ.push_back(s);
        @(posedge Clk); #1;
        Cs = 1'b1; Rd = 1'b1; Wr = 1'b0; Addr = 12'h040; DataWr = 16'h3333;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!PRd && n < 50);
        check("PRd before reset", 32'(PRd), 32'd1);
        @(negedge Clk);
        @(negedge Clk);
        check("DataRd pre-reset", 32'(DataRd), 32'h0F0F);
        check("Wait in ACK", 32'(Wait), 32'd1);
        #2 ResetN = 1'b0;
        #1;
        check("ACK reset Wait", 32'(Wait), 32'd0);
        check("ACK reset PRd", 32'(PRd), 32'd0);
        check("ACK reset PWr", 32'(PWr), 32'd0);
        check("ACK reset DataRd", 32'(DataRd), 32'd0);
        check("ACK reset PAddr", 32'(PAddr), 32'd0);
        @(negedge Clk);
        Cs = 1'b0; Rd = 1'b0;
        #2 ResetN = 1'b1;
        ackEnable = 1'b1;

        // Wait-state registers are back at 2 after reset.
        ackData = 16'h7777;
        hostAccess(1'b1, 12'h050, 16'h4444, 2, 1'b1, 16'h7777, 1'b0, 0, 1'b0, 2'd0, 4'd0);
        hostAccess(1'b0, 12'h500, 16'h6666, 2, 1'b1, 16'h7777, 1'b0, 0, 1'b0, 2'd0, 4'd0);

        repeat (3) @(negedge Clk);
        check("strobe queue drained", strobeQ.size(), 0);
        check("completion queue drained", doneQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
